hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage LEGv8 datapath. Sits beside the decode stage and keeps a 3-entry scoreboard of in-flight register writers (EX, MEM, WB). It compares the decode-stage source registers against that scoreboard to stall fetch and decode, insert bubbles into ID/EX, and squash younger instructions on a taken branch. It also counts stall cycles and, when configured, produces EX-stage forwarding selects.

## Interface
- No parameters; register index width fixed at 5, XZR index fixed at 31.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- valid_D  in  1  decode stage holds a real instruction
- ra1_D  in  5  first source register (instr_D[9:5])
- ra2_D  in  5  second source register (post reg2loc mux)
- use1_D, use2_D  in  1 each  instruction actually reads ra1_D / ra2_D
- regWrite_D  in  1  decode instruction writes the register file
- memRead_D  in  1  decode instruction is a load (LDUR)
- wa3_D  in  5  destination register of decode instruction
- flush_M  in  1  branch taken, resolved in MEM this cycle
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID register
- bubble_E  out  1  load a NOP into ID/EX
- flush_D  out  1  clear IF/ID register
- fwdA_E, fwdB_E  out  2  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result
- stall_cnt  out  32  total stall cycles since reset

## Operation
- Scoreboard slots ex, mem and wb each hold {v, rd, ld}. Slot ex also holds src1, src2 and their use bits.
- Each cycle, wb←mem, mem←ex, and ex←new.
- new = {valid_D & regWrite_D & (wa3_D≠31), wa3_D, memRead_D, ra1_D, ra2_D, use bits}.
- new is forced to invalid (bubble) when bubble_E is 1.
- Source match: hit(s,r) = use & s.v & (s.rd==r) & (r≠31). XZR never causes a hazard.
- Without FORWARDING_EN: hz = a hit on either source against ex, mem or wb.
  - The regfile writes at the end of WB, so a reader in D alongside the writer in WB must stall.
- With FORWARDING_EN: hz = a hit on either source against ex only when ex.ld=1 (load-use).
- hz is qualified by valid_D.
- Outputs, with flush_M having priority:
  - flush_M=1: flush_D=1, bubble_E=1, stall_F=stall_D=0. The slot ex entry is invalidated before shifting (mem←invalid), since the instruction in EX is younger than the branch.
  - else hz=1: stall_F=stall_D=bubble_E=1, flush_D=0.
  - else: all 0.
- stall_cnt increments when stall_D=1. It saturates at 0xFFFF_FFFF.
- Forwarding, computed from slot ex sources:
  - fwdA_E=10 if mem.v & !mem.ld & mem.rd==ex.src1≠31.
  - else 01 if wb.v & wb.rd==ex.src1≠31.
  - else 00.
  - fwdB_E is the same rule on src2. MEM has priority over WB.

## Timing
- stall_F, stall_D, bubble_E, flush_D, fwdA_E and fwdB_E are combinational from current inputs and state, valid in the same cycle.
- Scoreboard and stall_cnt update on posedge clk.
- Reset (async, any time, including mid-stall): all slots invalid and stall_cnt=0. All outputs go to 0 immediately.
- Non-forwarding RAW distance 1: 3 stall cycles. Distance 2: 2 cycles. Distance 3: 1 cycle.
- Forwarding load-use: exactly 1 stall cycle. ALU-ALU: 0 stall cycles.
- flush_M in the same cycle as hz: flush wins and stall_cnt does not increment.

## Configuration
- FORWARDING_EN defined: only load-use stalls, and fwdA_E/fwdB_E are driven as above.
- FORWARDING_EN undefined: stall on any pending writer in EX, MEM or WB. fwdA_E/fwdB_E are tied to 00, and the source fields of slot ex are not required.

## Test plan
- Reset mid-stall: with a 3-cycle stall in progress, assert reset → all outputs 0 and stall_cnt=0 immediately; the scoreboard is empty after release.
- No forwarding, ADD X1 then SUB X2,X1,X3 back-to-back → stall_D=1 for 3 cycles, then 0; stall_cnt=3.
- FORWARDING_EN, LDUR X5 then ADD X6,X5,X7 → 1 stall cycle with bubble_E=1; in the cycle the ADD is in EX, fwdA_E=01.
- FORWARDING_EN, ADD X1 then ADD X2,X1,X1 → no stall; fwdA_E=fwdB_E=10 while the consumer is in EX.
- Writer to X31 (XZR) followed by a reader of X31 → no stall and fwd=00.
- flush_M=1 while a hazard is active → flush_D=bubble_E=1, stall_D=0; the slot entering mem is invalid and stall_cnt is unchanged.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: LEGv8 5-stage hazard unit. Tracks EX/MEM/WB register writers,
// stalls F/D, bubbles ID/EX, flushes IF/ID on a taken branch and counts stalls.
// Ports: clk, reset (async high); decode-stage sources/dest/controls in;
// stall_F, stall_D, bubble_E, flush_D, fwdA_E, fwdB_E, stall_cnt out.
// Optional macro FORWARDING_EN: only load-use stalls, EX forwarding selects.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_D,
  input  logic [4:0]  ra1_D,
  input  logic [4:0]  ra2_D,
  input  logic        use1_D,
  input  logic        use2_D,
  input  logic        regWrite_D,
  input  logic        memRead_D,
  input  logic [4:0]  wa3_D,
  input  logic        flush_M,
  output logic        stall_F,
  output logic        stall_D,
  output logic        bubble_E,
  output logic        flush_D,
  output logic [1:0]  fwdA_E,
  output logic [1:0]  fwdB_E,
  output logic [31:0] stall_cnt
);

  localparam logic [4:0] XZR = 5'd31;

  logic       ex_v_q,  ex_v_d;
  logic [4:0] ex_rd_q, ex_rd_d;
  logic       mem_v_q, mem_v_d;
  logic [4:0] mem_rd_q, mem_rd_d;
  logic       wb_v_q,  wb_v_d;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic       hz;
  logic       hz_only;

`ifdef FORWARDING_EN
  logic       ex_ld_q,  ex_ld_d;
  logic       mem_ld_q, mem_ld_d;
  logic [4:0] ex_s1_q,  ex_s1_d;
  logic [4:0] ex_s2_q,  ex_s2_d;
`else
  logic       unused_ok;
  assign unused_ok = memRead_D;
`endif

  function automatic logic hit(
    input logic       u,
    input logic       v,
    input logic [4:0] rd,
    input logic [4:0] r
  );
    return u & v & (rd == r) & (r != XZR);
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fsel(input logic [4:0] s);
    if (mem_v_q && !mem_ld_q && mem_rd_q == s && s != XZR)
      return 2'b10;
    else if (wb_v_q && wb_rd_q == s && s != XZR)
      return 2'b01;
    else
      return 2'b00;
  endfunction
`endif

  always_comb begin
`ifdef FORWARDING_EN
    hz = ex_ld_q
       & (hit(use1_D, ex_v_q, ex_rd_q, ra1_D)
        | hit(use2_D, ex_v_q, ex_rd_q, ra2_D));
`else
    // Regfile writes at end of WB, so a WB writer still blocks a D reader.
    hz = hit(use1_D, ex_v_q,  ex_rd_q,  ra1_D)
       | hit(use2_D, ex_v_q,  ex_rd_q,  ra2_D)
       | hit(use1_D, mem_v_q, mem_rd_q, ra1_D)
       | hit(use2_D, mem_v_q, mem_rd_q, ra2_D)
       | hit(use1_D, wb_v_q,  wb_rd_q,  ra1_D)
       | hit(use2_D, wb_v_q,  wb_rd_q,  ra2_D);
`endif
    hz = hz & valid_D;
    hz_only = hz & ~flush_M;

    stall_F  = 1'b0;
    stall_D  = 1'b0;
    bubble_E = 1'b0;
    flush_D  = 1'b0;
    unique case (1'b1)
      flush_M: begin
        flush_D  = 1'b1;
        bubble_E = 1'b1;
      end
      hz_only: begin
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        bubble_E = 1'b1;
      end
      default: ;
    endcase

    ex_v_d  = valid_D & regWrite_D & (wa3_D != XZR);
    ex_rd_d = wa3_D;
`ifdef FORWARDING_EN
    ex_ld_d = memRead_D;
    ex_s1_d = ra1_D;
    ex_s2_d = ra2_D;
`endif
    if (bubble_E) begin
      ex_v_d  = 1'b0;
      ex_rd_d = 5'd0;
`ifdef FORWARDING_EN
      ex_ld_d = 1'b0;
      ex_s1_d = 5'd0;
      ex_s2_d = 5'd0;
`endif
    end

    // The instruction in EX is younger than the branch resolving in MEM.
    mem_v_d  = ex_v_q & ~flush_M;
    mem_rd_d = ex_rd_q;
`ifdef FORWARDING_EN
    mem_ld_d = ex_ld_q;
`endif
    wb_v_d   = mem_v_q;
    wb_rd_d  = mem_rd_q;

    cnt_d = cnt_q;
    if (stall_D && cnt_q != 32'hFFFF_FFFF)
      cnt_d = cnt_q + 32'd1;

`ifdef FORWARDING_EN
    fwdA_E = fsel(ex_s1_q);
    fwdB_E = fsel(ex_s2_q);
`else
    fwdA_E = 2'b00;
    fwdB_E = 2'b00;
`endif
  end

  assign stall_cnt = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v_q   <= 1'b0;
      ex_rd_q  <= 5'd0;
      mem_v_q  <= 1'b0;
      mem_rd_q <= 5'd0;
      wb_v_q   <= 1'b0;
      wb_rd_q  <= 5'd0;
      cnt_q    <= 32'd0;
`ifdef FORWARDING_EN
      ex_ld_q  <= 1'b0;
      mem_ld_q <= 1'b0;
      ex_s1_q  <= 5'd0;
      ex_s2_q  <= 5'd0;
`endif
    end else begin
      ex_v_q   <= ex_v_d;
      ex_rd_q  <= ex_rd_d;
      mem_v_q  <= mem_v_d;
      mem_rd_q <= mem_rd_d;
      wb_v_q   <= wb_v_d;
      wb_rd_q  <= wb_rd_d;
      cnt_q    <= cnt_d;
`ifdef FORWARDING_EN
      ex_ld_q  <= ex_ld_d;
      mem_ld_q <= mem_ld_d;
      ex_s1_q  <= ex_s1_d;
      ex_s2_q  <= ex_s2_d;
`endif
    end
  end

endmodule
